hw_timer: RTL and testbench

- Memory-mapped countdown timer on the CPU peripheral bus.
- Drives one HWInt line into the coprocessor-0 interrupt logic; it is the interrupt source at the device end of that interface.
- The CPU programs it with sw/lw through a 3-word register window.
- On expiry it raises IRQ, either as a held level (one-shot mode) or as a single-cycle pulse (auto-reload mode).

---
 rtl/hw_timer.sv | 137 +++++++++++++
 tb/tb_hw_timer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hw_timer.sv
// hw_timer: memory-mapped countdown timer raising IRQ as a held level (one-shot) or 1-cycle pulse (auto-reload).
// Optional count prescaler is built in when TIMER_PRESCALE_EN is defined.
module hw_timer #(
  parameter int BASE_WORDS   = 3,
  parameter int PRESCALE_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  // state | meaning
  // IDLE  | stopped, waiting for Enable
  // LOAD  | copy PRESET into COUNT
  // CNT   | counting down
  // INT   | expired; one-shot drops Enable, auto-reload drops the flag and restarts
  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  if (PRESCALE_DIV < 1) begin : g_div_check
    $error("hw_timer: PRESCALE_DIV must be >= 1");
  end

  state_t      state;
  logic        enable;
  logic [1:0]  mode;
  logic        im;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;
  logic        addr_hit;
  logic        ctrl_wr;
  logic        preset_wr;
  logic        auto_reload;
  logic        tick;
  logic        unused_din_hi;

  assign addr_hit      = 32'(Addr) < BASE_WORDS;
  assign ctrl_wr       = WE && addr_hit && (Addr == 2'd0);
  assign preset_wr     = WE && addr_hit && (Addr == 2'd1);
  assign auto_reload   = (mode == 2'b01);
  assign unused_din_hi = ^Din[31:4];

`ifdef TIMER_PRESCALE_EN
  localparam int PW = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE_DIV - 1);

  logic [PW-1:0] prescaler;

  assign tick = (prescaler == PS_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler <= '0;
    end else if (state == LOAD) begin
      prescaler <= '0;
    end else if (state == CNT && enable) begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      enable   <= 1'b0;
      mode     <= 2'b00;
      im       <= 1'b0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state    <= LOAD;
            irq_flag <= 1'b0;
          end
        end
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: begin
          if (!enable) begin
            state <= IDLE;
          end else if (tick) begin
            // COUNT of 0 or 1 both expire, so PRESET=0 behaves as PRESET=1
            if (count > 32'd1) begin
              count <= count - 32'd1;
            end else begin
              count    <= '0;
              irq_flag <= 1'b1;
              state    <= INT;
            end
          end
        end
        INT: begin
          state <= IDLE;
          if (auto_reload) irq_flag <= 1'b0;
          else             enable   <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      // bus writes come last so they win over same-edge FSM updates
      if (preset_wr) preset <= Din;
      if (ctrl_wr) begin
        enable   <= Din[0];
        mode     <= Din[2:1];
        im       <= Din[3];
        irq_flag <= 1'b0;
        if (!Din[0]) state <= IDLE;
      end
    end
  end

  always_comb begin
    Dout = '0;
    if (addr_hit) begin
      case (Addr)
        2'd0:    Dout = {28'b0, im, mode, enable};
        2'd1:    Dout = preset;
        2'd2:    Dout = count;
        default: Dout = '0;
      endcase
    end
  end

  assign IRQ = irq_flag & im;

endmodule

// File: tb/tb_hw_timer.sv
// tb_hw_timer: randomized and directed runs of hw_timer checked against closed-form timing of each run.
// Expected COUNT/CTRL/IRQ are computed from the load edge, the period and the prescale factor.
module tb_hw_timer;

`ifdef TIMER_PRESCALE_EN
  localparam int DIV = 4;
`else
  localparam int DIV = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int total = 0;
  int bad   = 0;

  hw_timer #(.BASE_WORDS(3), .PRESCALE_DIV(4)) dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .WE   (WE),
    .Din  (Din),
    .Dout (Dout),
    .IRQ  (IRQ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    Addr = a;
    #1;
    d = Dout;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    Addr = a;
    Din  = d;
    WE   = 1'b1;
    @(posedge clk);
    #1;
    WE  = 1'b0;
    Din = '0;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    WE    = 1'b0;
    Addr  = 2'd0;
    Din   = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Edge numbering: the enabling CTRL write is edge 0, COUNT is loaded at edge 2.
  function automatic int run_len(input int p);
    return ((p == 0) ? 1 : p) * DIV;
  endfunction

  function automatic int exp_count(input int e, input int p, input bit auto_m, input int c0);
    int pd;
    int j;
    if (e < 2) return c0;
    pd = run_len(p);
    j  = e - 2;
    if (auto_m) j = j % (pd + 3);
    if (j < pd) return p - j / DIV;
    return 0;
  endfunction

  function automatic bit exp_irq(input int e, input int p, input bit auto_m, input bit im);
    int pd;
    int j;
    if (!im || e < 2) return 1'b0;
    pd = run_len(p);
    j  = e - 2;
    if (auto_m) return (j % (pd + 3)) == pd;
    return j >= pd;
  endfunction

  function automatic bit exp_en(input int e, input int p, input bit auto_m);
    if (auto_m) return 1'b1;
    return e <= run_len(p) + 2;
  endfunction

  task automatic run(input int p, input logic [1:0] mode, input bit im, input int ncyc,
                     input int wr_edge, input int newp, input int stop_edge, input int c0,
                     output int c_end);
    bit          auto_m;
    bit          stopped;
    int          eff;
    int          ec;
    logic [31:0] d;
    auto_m = (mode == 2'b01);
    ec     = c0;
    bus_write(2'd0, {28'b0, im, mode, 1'b1});
    for (int e = 1; e <= ncyc; e++) begin
      if (e == stop_edge) begin
        Addr = 2'd0; Din = {28'b0, im, mode, 1'b0}; WE = 1'b1;
      end else if (e == wr_edge) begin
        Addr = 2'd1; Din = 32'(newp); WE = 1'b1;
      end
      @(posedge clk);
      #1;
      WE  = 1'b0;
      Din = '0;
      stopped = (stop_edge != 0) && (e >= stop_edge);
      eff     = stopped ? stop_edge : e;
      ec      = exp_count(eff, p, auto_m, c0);
      rd(2'd2, d);
      chk("count", d, 32'(ec));
      rd(2'd0, d);
      chk("ctrl", d, {28'b0, im, mode, stopped ? 1'b0 : exp_en(e, p, auto_m)});
      chk("irq", {31'b0, IRQ}, {31'b0, stopped ? 1'b0 : exp_irq(e, p, auto_m, im)});
    end
    c_end = ec;
  endtask

  task automatic clear_check(input bit im2);
    logic [31:0] d;
    bus_write(2'd0, {28'b0, im2, 3'b000});
    rd(2'd0, d);
    chk("ctrl_clr", d, {28'b0, im2, 3'b000});
    chk("irq_clr", {31'b0, IRQ}, 32'd0);
    @(posedge clk);
    #1;
    chk("irq_clr_hold", {31'b0, IRQ}, 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    int          c;
    int          p;
    int          newp;
    int          ncyc;
    int          wr_edge;
    int          stop_edge;
    int          e7;
    logic [1:0]  mode;
    bit          im;

    reset_dut();
    rd(2'd0, d); chk("rst_ctrl", d, 32'd0);
    rd(2'd1, d); chk("rst_preset", d, 32'd0);
    rd(2'd2, d); chk("rst_count", d, 32'd0);
    chk("rst_irq", {31'b0, IRQ}, 32'd0);

    bus_write(2'd1, 32'd9);
    bus_write(2'd2, 32'h55);
    bus_write(2'd3, 32'h77);
    rd(2'd2, d); chk("count_ro", d, 32'd0);
    rd(2'd3, d); chk("addr3_zero", d, 32'd0);
    rd(2'd1, d); chk("preset_rw", d, 32'd9);
    rd(2'd0, d); chk("ctrl_untouched", d, 32'd0);

    // one-shot, IM=1, then clear
    reset_dut();
    bus_write(2'd1, 32'd5);
    run(5, 2'b00, 1'b1, run_len(5) + 8, 0, 0, 0, 0, c);
    clear_check(1'b0);

    // auto-reload pulses
    reset_dut();
    bus_write(2'd1, 32'd3);
    run(3, 2'b01, 1'b1, 3 * (run_len(3) + 3) + 4, 0, 0, 0, 0, c);
    clear_check(1'b0);

    // masked one-shot; unmasking via CTRL write clears the flag
    reset_dut();
    bus_write(2'd1, 32'd2);
    run(2, 2'b00, 1'b0, run_len(2) + 8, 0, 0, 0, 0, c);
    clear_check(1'b1);

    // PRESET rewrite mid-count, stop, re-enable from the new value
    reset_dut();
    bus_write(2'd1, 32'd10);
    run(10, 2'b00, 1'b1, run_len(10) + 8, 4, 2, 8, 0, c);
    run(2, 2'b00, 1'b1, run_len(2) + 8, 0, 0, 0, c, c);
    clear_check(1'b0);

    // reset in the middle of a run
    reset_dut();
    bus_write(2'd1, 32'd20);
    bus_write(2'd0, 32'h9);
    e7 = 2 + (20 - 7) * DIV;
    for (int e = 1; e <= e7; e++) begin
      @(posedge clk);
      #1;
    end
    rd(2'd2, d); chk("cnt_at_7", d, 32'd7);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    rd(2'd0, d); chk("mid_rst_ctrl", d, 32'd0);
    rd(2'd1, d); chk("mid_rst_preset", d, 32'd0);
    rd(2'd2, d); chk("mid_rst_count", d, 32'd0);
    chk("mid_rst_irq", {31'b0, IRQ}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rd(2'd2, d); chk("mid_rst_idle", d, 32'd0);

    for (int it = 0; it < 20; it++) begin
      reset_dut();
      p    = int'($urandom_range(0, 12));
      mode = 2'($urandom_range(0, 3));
      im   = 1'($urandom_range(0, 1));
      newp = int'($urandom_range(0, 12));
      ncyc = (mode == 2'b01) ? 3 * (run_len(p) + 3) + 4 : run_len(p) + 8;
      stop_edge = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, ncyc)) : 0;
      wr_edge   = (mode != 2'b01 && $urandom_range(0, 1) == 1) ? int'($urandom_range(2, ncyc)) : 0;
      if (wr_edge == stop_edge) wr_edge = 0;
      bus_write(2'd1, 32'(p));
      run(p, mode, im, ncyc, wr_edge, newp, stop_edge, 0, c);
      if (wr_edge != 0) begin
        run(newp, mode, im, run_len(newp) + 8, 0, 0, 0, c, c);
      end
      clear_check(1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
